// File: rtl/imm_pkg.sv
// imm_pkg: shared types and constants for the instruction-word assembler.
//   imm_kind_e    request format codes carried on req_kind
//   OPC_OP_IMM    opcode used for ADDI words
//   OPC_LUI       opcode used for LUI words
//   NOP_INSTR     word substituted when an immediate cannot be encoded
//   make_addi/make_lui build the two words a load-immediate can expand to
package imm_pkg;

  typedef enum logic [2:0] {
    KIND_I      = 3'b000,
    KIND_S      = 3'b001,
    KIND_B      = 3'b010,
    KIND_U      = 3'b011,
    KIND_J      = 3'b100,
    KIND_UIMM   = 3'b101,
    KIND_BYPASS = 3'b110,
    KIND_LI     = 3'b111
  } imm_kind_e;

  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  // ADDI rd, rs1, imm12 (funct3 = 000)
  function automatic logic [31:0] make_addi(input logic [4:0] rd,
                                            input logic [4:0] rs1,
                                            input logic [11:0] imm12);
    return {imm12, rs1, 3'b000, rd, OPC_OP_IMM};
  endfunction

  // LUI rd, hi20
  function automatic logic [31:0] make_lui(input logic [4:0] rd,
                                           input logic [19:0] hi20);
    return {hi20, rd, OPC_LUI};
  endfunction

endpackage

// File: rtl/imm_pack.sv
// imm_pack: purely combinational packer for one request word. Scatters the
// immediate into the RV32I bit positions of the requested format, places the
// register/funct3 fields, and range-checks the immediate. A failed check
// replaces the word with NOP and raises err.
//   kind     request format
//   opcode   instr[6:0]
//   rd, rs1, rs2, funct3, funct7   standard instruction fields
//   imm      full 32-bit two's complement immediate
//   instr    packed word (NOP on error)
//   err      immediate not representable in this format
// LI requests are expanded by the parent; for that kind the outputs are NOP/0.
module imm_pack
  import imm_pkg::*;
(
  input  imm_kind_e   kind,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  logic fits_12;
  logic fits_13;
  logic fits_21;

  // A signed value fits in N bits when every bit from N-1 upward equals the
  // sign bit. B/J additionally demand an even value, which turns the upper
  // bound from 2^(N-1)-1 into 2^(N-1)-2.
  assign fits_12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fits_13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fits_21 = (&imm[31:20]) || !(|imm[31:20]);

  logic [31:0] word;
  logic        bad;

  always_comb begin
    word = NOP_INSTR;
    bad  = 1'b0;
    case (kind)
      KIND_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        bad  = !fits_12;
      end
      KIND_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        bad  = !fits_12;
      end
      KIND_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        bad  = !fits_13 || imm[0];
      end
      KIND_U: begin
        word = {imm[31:12], rd, opcode};
        bad  = |imm[11:0];
      end
      KIND_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        bad  = !fits_21 || imm[0];
      end
      KIND_UIMM: begin
        word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        bad  = |imm[31:5];
      end
      KIND_BYPASS: begin
        word = {imm[31:7], opcode};
        bad  = 1'b0;
      end
      KIND_LI: begin
        word = NOP_INSTR;
        bad  = 1'b0;
      end
      default: begin
        word = NOP_INSTR;
        bad  = 1'b0;
      end
    endcase
  end

  assign instr = bad ? NOP_INSTR : word;
  assign err   = bad;

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: instruction-word assembler feeding the debug instruction
// injector. Accepts one request per valid/ready handshake, emits one or two
// 32-bit words per request over a valid/ready output port.
//   clk, rst         clock and synchronous active-high reset
//   req_valid/ready  request handshake
//   req_kind         format (see imm_kind_e); 111 = load-immediate
//   req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm
//   out_valid/ready  output handshake
//   out_instr        assembled word
//   out_last         final word of the current request
//   out_err          immediate was not representable; word is NOP
module imm_encoder
  import imm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [6:0]  req_opcode,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HOLD_LO = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_last_q, out_last_d;
  logic        out_err_q, out_err_d;
  logic [31:0] lo_instr_q, lo_instr_d;

  imm_kind_e   kind;
  logic [31:0] pack_instr;
  logic        pack_err;

  assign kind = imm_kind_e'(req_kind);

  imm_pack u_pack (
    .kind   (kind),
    .opcode (req_opcode),
    .rd     (req_rd),
    .rs1    (req_rs1),
    .rs2    (req_rs2),
    .funct3 (req_funct3),
    .funct7 (req_funct7),
    .imm    (req_imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  // Load-immediate split. The upper part is rounded by +0x800 so that the
  // sign-extended low 12 bits added back by ADDI land on the exact value.
  logic        li_fits;
  logic [31:0] li_sum;
  logic [11:0] li_lo;

  assign li_fits = (&req_imm[31:11]) || !(|req_imm[31:11]);
  assign li_sum  = req_imm + 32'h0000_0800;
  assign li_lo   = req_imm[11:0];

  logic req_accept;
  logic out_fire;

  // A new request may enter only when the output register is free or is
  // being drained in this same cycle, so accept and drain can overlap.
  assign req_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign req_accept = req_valid && req_ready;
  assign out_fire   = out_valid_q && out_ready;

  // Next-state logic: IDLE loads the first (or only) word of a request;
  // HOLD_LO swaps in the latched ADDI once the LUI has been taken.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    lo_instr_d  = lo_instr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_accept) begin
          out_valid_d = 1'b1;
          if (kind == KIND_LI) begin
            out_err_d = 1'b0;
            if (li_fits) begin
              out_instr_d = make_addi(req_rd, 5'd0, req_imm[11:0]);
              out_last_d  = 1'b1;
            end else if (li_lo == 12'd0) begin
              out_instr_d = make_lui(req_rd, li_sum[31:12]);
              out_last_d  = 1'b1;
            end else begin
              out_instr_d = make_lui(req_rd, li_sum[31:12]);
              out_last_d  = 1'b0;
              lo_instr_d  = make_addi(req_rd, req_rd, li_lo);
              state_d     = ST_HOLD_LO;
            end
          end else begin
            out_instr_d = pack_instr;
            out_last_d  = 1'b1;
            out_err_d   = pack_err;
          end
        end else if (out_fire) begin
          out_valid_d = 1'b0;
        end
      end
      ST_HOLD_LO: begin
        if (out_fire) begin
          out_valid_d = 1'b1;
          out_instr_d = lo_instr_q;
          out_last_d  = 1'b1;
          out_err_d   = 1'b0;
          lo_instr_d  = 32'd0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any pending ADDI of a pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      lo_instr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
      lo_instr_q  <= lo_instr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed cases for load-immediate splitting, branch/I range
// limits and mid-pair reset, followed by randomized requests under random
// output back-pressure. Expected words come from a behavioural model and are
// queued on acceptance; an independent monitor compares every presented word.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [6:0]  req_opcode;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;

  imm_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_opcode (req_opcode),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_funct3 (req_funct3),
    .req_funct7 (req_funct7),
    .req_imm    (req_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_last   (out_last),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;

  logic [31:0] edge_vals [0:19] = '{
    32'd0, 32'd31, 32'd32, 32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF,
    32'd4094, 32'd4096, 32'hFFFF_F000, 32'hFFFF_EFFE, 32'h000F_FFFE,
    32'h0010_0000, 32'hFFF0_0000, 32'hFFEF_FFFE, 32'h1234_5FFF,
    32'h0000_1000, 32'h7FFF_F800, 32'h8000_0000, 32'hFFFF_FFFF
  };

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired (got timeout, expected event)", name);
  endtask

  task automatic pushExpect(input logic [31:0] instr, input logic last,
                            input logic err);
    exp_t e;
    e.instr = instr;
    e.last  = last;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] addiWord(input logic [31:0] rd,
                                           input logic [31:0] rs1,
                                           input logic [31:0] imm);
    return 32'h13 | (rd << 7) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
  endfunction

  // Behavioural reference: arithmetic range tests and field shifts.
  task automatic modelExpect(input logic [2:0] kind, input logic [6:0] opc,
                             input logic [4:0] rd5, input logic [4:0] rs15,
                             input logic [4:0] rs25, input logic [2:0] f33,
                             input logic [6:0] f77, input logic [31:0] imm);
    logic [31:0] op, rd, rs1, rs2, f3, f7, w, hi, lo;
    int          s;
    bit          bad;
    op  = 32'(opc);
    rd  = 32'(rd5);
    rs1 = 32'(rs15);
    rs2 = 32'(rs25);
    f3  = 32'(f33);
    f7  = 32'(f77);
    s   = $signed(imm);
    bad = 1'b0;
    w   = 32'h13;
    case (kind)
      3'd0: begin
        bad = (s < -2048) || (s > 2047);
        w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      end
      3'd1: begin
        bad = (s < -2048) || (s > 2047);
        w = op | ((imm & 32'h1F) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
            | (((imm >> 5) & 32'h7F) << 25);
      end
      3'd2: begin
        bad = (s < -4096) || (s > 4094) || (imm[0] == 1'b1);
        w = op | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
            | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
            | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
      end
      3'd3: begin
        bad = (imm % 32'd4096) != 32'd0;
        w = op | (rd << 7) | (imm & 32'hFFFF_F000);
      end
      3'd4: begin
        bad = (s < -(1 << 20)) || (s > (1 << 20) - 2) || (imm[0] == 1'b1);
        w = op | (rd << 7) | (imm & 32'h000F_F000) | (((imm >> 11) & 32'h1) << 20)
            | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
      end
      3'd5: begin
        bad = imm > 32'd31;
        w = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | (imm << 20) | (f7 << 25);
      end
      3'd6: begin
        w = (imm & 32'hFFFF_FF80) | op;
      end
      default: begin
        if (s >= -2048 && s <= 2047) begin
          pushExpect(addiWord(rd, 32'd0, imm), 1'b1, 1'b0);
        end else begin
          hi = (imm + 32'h800) >> 12;
          lo = imm & 32'hFFF;
          pushExpect((hi << 12) | (rd << 7) | 32'h37, (lo == 32'd0), 1'b0);
          if (lo != 32'd0) pushExpect(addiWord(rd, rd, lo), 1'b1, 1'b0);
        end
      end
    endcase
    if (kind != 3'd7) begin
      if (bad) pushExpect(32'h13, 1'b1, 1'b1);
      else     pushExpect(w, 1'b1, 1'b0);
    end
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [2:0] kind, input logic [6:0] opc,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm,
                               input bit use_model);
    bit accepted;
    bit ready_seen;
    req_kind   = kind;
    req_opcode = opc;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_funct3 = f3;
    req_funct7 = f7;
    req_imm    = imm;
    req_valid  = 1'b1;
    accepted   = 1'b0;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      ready_seen = req_ready;
      @(posedge clk);
      #1;
      if (ready_seen) accepted = 1'b1;
    end
    req_valid = 1'b0;
    if (!accepted) reportFail("req_accept");
    else if (use_model) modelExpect(kind, opc, rd, rs1, rs2, f3, f7, imm);
  endtask

  task automatic waitDrain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() != 0) reportFail("drain");
    #1;
  endtask

  // Back-pressure generator for the randomized phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every presented word must match the scoreboard head; it is
  // popped on handshake, so a stalled word is checked again each cycle.
  initial begin
    bit prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !out_valid) checkOutput("valid_dropped", 32'(out_valid), 32'd1);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_word", out_instr, 32'hxxxx_xxxx);
          end else begin
            checkOutput("out_instr", out_instr, exp_q[0].instr);
            checkOutput("out_last", 32'(out_last), 32'(exp_q[0].last));
            checkOutput("out_err", 32'(out_err), 32'(exp_q[0].err));
            if (!out_last) checkOutput("ready_in_pair", 32'(req_ready), 32'd0);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
      end
    end
  end

  initial begin
    logic [31:0] imm;
    req_valid  = 1'b0;
    req_kind   = 3'd0;
    req_opcode = 7'd0;
    req_rd     = 5'd0;
    req_rs1    = 5'd0;
    req_rs2    = 5'd0;
    req_funct3 = 3'd0;
    req_funct7 = 7'd0;
    req_imm    = 32'd0;
    out_ready  = 1'b1;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_instr", out_instr, 32'd0);
    checkOutput("reset_last", 32'(out_last), 32'd0);
    checkOutput("reset_err", 32'(out_err), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] directed cases");
    pushExpect(32'h0050_0513, 1'b1, 1'b0);
    applyStimulus(3'd7, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
    pushExpect(32'h1234_62B7, 1'b0, 1'b0);
    pushExpect(32'hFFF2_8293, 1'b1, 1'b0);
    applyStimulus(3'd7, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 1'b0);
    @(negedge clk);
    checkOutput("pair_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    pushExpect(32'h0000_10B7, 1'b1, 1'b0);
    applyStimulus(3'd7, 7'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 1'b0);
    pushExpect(32'hFE20_9EE3, 1'b1, 1'b0);
    applyStimulus(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'hFFFF_FFFC, 1'b0);
    pushExpect(32'h0000_0013, 1'b1, 1'b1);
    applyStimulus(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'hFFFF_FFFD, 1'b0);
    pushExpect(32'h0000_0013, 1'b1, 1'b1);
    applyStimulus(3'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
    pushExpect(32'h8002_0193, 1'b1, 1'b0);
    applyStimulus(3'd0, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 1'b0);
    waitDrain();

    $display("[TB] stalled pair then reset in HOLD_LO");
    out_ready = 1'b0;
    pushExpect(32'h1234_62B7, 1'b0, 1'b0);
    pushExpect(32'hFFF2_8293, 1'b1, 1'b0);
    applyStimulus(3'd7, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rst_pair_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_pair_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_addi_after_rst", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    $display("[TB] randomized requests");
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 63)) - 32'd32;
        1: imm = edge_vals[$urandom_range(0, 19)];
        2: imm = $urandom;
        default: imm = $urandom & 32'hFFFF_F000;
      endcase
      applyStimulus(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom),
                    5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                    imm, 1'b1);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
